// File: rtl/base_sram_arbiter.sv
// Base SRAM arbiter: shares the single base SRAM chip between instruction fetch and data memory.
// Latency: a read is ready WAIT_CYCLES+1 cycles and a write WAIT_CYCLES+2 cycles after the request is first seen idle.
// Backpressure: a requester holds req until its one-cycle ready pulse; *_stall flags every cycle it is still waiting.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   if_*                   fetch port (read only, full-word)
//   dm_*                   data port (read/write, byte enables)
//   base_ram_*             SRAM board pins; the data bus is driven only while writing
// Optional build macro: SRAM_ARB_FAIR_EN (alternating grant on conflict instead of fixed DM priority).
module base_sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2  // strobe-low cycles per access, 1..15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ready_o,
  output logic [31:0] if_rdata_o,
  output logic        if_stall_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_be_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_rdata_o,
  output logic        dm_stall_o,
  inout  wire  [31:0] base_ram_data_io,
  output logic [19:0] base_ram_addr_o,
  output logic [3:0]  base_ram_be_n_o,
  output logic        base_ram_ce_n_o,
  output logic        base_ram_oe_n_o,
  output logic        base_ram_we_n_o
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_WHOLD, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        owner_dm_q;   // 1 = DM owns the current access, 0 = IF
  logic [3:0]  cnt_q;
  logic [19:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        grant_dm;
  logic        any_req;
  logic        cnt_last;
  logic        drive_bus;

  // Only word address bits 21:2 reach the chip; upstream decode owns the rest.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:22], if_addr_i[1:0],
                              dm_addr_i[31:22], dm_addr_i[1:0]};

  assign any_req  = if_req_i | dm_req_i;
  assign cnt_last = (cnt_q == 4'(WAIT_CYCLES - 1));

`ifdef SRAM_ARB_FAIR_EN
  // On conflict the port that did not win the previous grant goes next.
  logic last_dm_q;
  assign grant_dm = dm_req_i & (~if_req_i | ~last_dm_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_dm_q <= 1'b0;
    end else if (state_q == S_IDLE && any_req) begin
      last_dm_q <= grant_dm;
    end
  end
`else
  assign grant_dm = dm_req_i;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = (grant_dm && dm_we_i) ? S_WRITE : S_READ;
      S_READ:  if (cnt_last) state_d = S_DONE;
      S_WRITE: if (cnt_last) state_d = S_WHOLD;
      S_WHOLD: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: pins are a pure function of state and latched request
  always_comb begin
    base_ram_ce_n_o = 1'b1;
    base_ram_oe_n_o = 1'b1;
    base_ram_we_n_o = 1'b1;
    base_ram_be_n_o = 4'hF;
    base_ram_addr_o = 20'h0;
    drive_bus       = 1'b0;
    if_ready_o      = 1'b0;
    dm_ready_o      = 1'b0;
    case (state_q)
      S_READ: begin
        base_ram_ce_n_o = 1'b0;
        base_ram_oe_n_o = 1'b0;
        base_ram_be_n_o = ~be_q;
        base_ram_addr_o = addr_q;
      end
      S_WRITE: begin
        base_ram_ce_n_o = 1'b0;
        base_ram_we_n_o = 1'b0;
        base_ram_be_n_o = ~be_q;
        base_ram_addr_o = addr_q;
        drive_bus       = 1'b1;
      end
      S_WHOLD: begin
        // we_n already high; chip stays selected and data held for hold time
        base_ram_ce_n_o = 1'b0;
        base_ram_be_n_o = ~be_q;
        base_ram_addr_o = addr_q;
        drive_bus       = 1'b1;
      end
      S_DONE: begin
        if_ready_o = ~owner_dm_q;
        dm_ready_o = owner_dm_q;
      end
      default: ;
    endcase
  end

  // Datapath: request latch, wait counter, read capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_dm_q <= 1'b0;
      cnt_q      <= 4'd0;
      addr_q     <= 20'h0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      if_rdata_q <= 32'h0;
      dm_rdata_q <= 32'h0;
    end else begin
      if (state_q == S_READ || state_q == S_WRITE) begin
        cnt_q <= cnt_last ? 4'd0 : cnt_q + 4'd1;
      end else begin
        cnt_q <= 4'd0;
      end

      if (state_q == S_IDLE && any_req) begin
        owner_dm_q <= grant_dm;
        if (grant_dm) begin
          addr_q  <= dm_addr_i[21:2];
          be_q    <= dm_be_i;
          wdata_q <= dm_wdata_i;
        end else begin
          addr_q  <= if_addr_i[21:2];
          be_q    <= 4'hF;
        end
      end

      if (state_q == S_READ && cnt_last) begin
        if (owner_dm_q) dm_rdata_q <= base_ram_data_io;
        else            if_rdata_q <= base_ram_data_io;
      end
    end
  end

  assign base_ram_data_io = drive_bus ? wdata_q : 32'hz;
  assign if_rdata_o       = if_rdata_q;
  assign dm_rdata_o       = dm_rdata_q;
  assign if_stall_o       = if_req_i & ~if_ready_o;
  assign dm_stall_o       = dm_req_i & ~dm_ready_o;

endmodule

// File: tb/tb_base_sram_arbiter.sv
// Directed bench for base_sram_arbiter with a byte-maskable SRAM model on the board bus.
module tb_base_sram_arbiter;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ready, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ready, dm_stall;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  wire  [31:0] ram_data;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ce_n, oe_n, we_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  base_sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ready_o(if_ready),
    .if_rdata_o(if_rdata), .if_stall_o(if_stall),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_ready_o(dm_ready), .dm_rdata_o(dm_rdata),
    .dm_stall_o(dm_stall),
    .base_ram_data_io(ram_data), .base_ram_addr_o(ram_addr),
    .base_ram_be_n_o(ram_be_n), .base_ram_ce_n_o(ce_n),
    .base_ram_oe_n_o(oe_n), .base_ram_we_n_o(we_n)
  );

  // SRAM model: 256 words, drives the bus while selected and output-enabled.
  logic [31:0] mem [0:255];
  logic        pre_vld = 1'b0;
  logic [7:0]  pre_addr;
  logic [31:0] pre_dat;

  assign ram_data = (!ce_n && !oe_n) ? mem[ram_addr[7:0]] : 32'hz;

  always @(posedge clk) begin
    if (pre_vld) mem[pre_addr] <= pre_dat;
    else if (!ce_n && !we_n) begin
      for (int b = 0; b < 4; b++)
        if (!ram_be_n[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_data[8*b +: 8];
    end
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_addr = a; pre_dat = d; pre_vld = 1'b1;
    @(posedge clk); #1 pre_vld = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          pre_en;
    logic [31:0] pre;
    int          exp_lat;
    logic [19:0] exp_addr;
    logic [3:0]  exp_be_n;
    logic [31:0] exp_word;  // read data, or memory word after a write
  } vec_t;

  vec_t vecs[6];
  bit   exp_ord[4];

  initial begin
    vec_t        v;
    int          n, strobe, dm_n, if_n, stall_bad, g;
    bit          done, rdy;
    logic [19:0] seen_addr;
    logic [3:0]  seen_be;
    logic [31:0] hold_bus, old_other;
    bit          got_ord[4];

    vecs[0] = '{0, 0, 4'hF, 32'h8000_0010, 32'h0,         1, 32'h1234_5678, W+1, 20'h00004, 4'h0, 32'h1234_5678};
    vecs[1] = '{1, 1, 4'h2, 32'h8000_0104, 32'hAABB_CCDD, 1, 32'h1122_3344, W+2, 20'h00041, 4'hD, 32'h1122_CC44};
    vecs[2] = '{1, 1, 4'h0, 32'h8000_0108, 32'hFFFF_FFFF, 1, 32'h5566_7788, W+2, 20'h00042, 4'hF, 32'h5566_7788};
    vecs[3] = '{1, 0, 4'hF, 32'h8000_0200, 32'h0,         1, 32'hDEAD_BEEF, W+1, 20'h00080, 4'h0, 32'hDEAD_BEEF};
    vecs[4] = '{1, 1, 4'hF, 32'h8000_000C, 32'hCAFE_F00D, 1, 32'h0,         W+2, 20'h00003, 4'h0, 32'hCAFE_F00D};
    vecs[5] = '{0, 0, 4'hF, 32'h8000_000C, 32'h0,         0, 32'h0,         W+1, 20'h00003, 4'h0, 32'hCAFE_F00D};
`ifdef SRAM_ARB_FAIR_EN
    exp_ord = '{1, 0, 1, 0};
`else
    exp_ord = '{1, 1, 1, 1};
`endif

    // ---- reset state
    rst_n = 1'b0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_be = 0;
    dm_addr = 0; dm_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ce_n", ce_n, 1); check("rst_oe_n", oe_n, 1); check("rst_we_n", we_n, 1);
    check("rst_be_n", ram_be_n, 4'hF); check("rst_addr", ram_addr, 0);
    check("rst_if_ready", if_ready, 0); check("rst_dm_ready", dm_ready, 0);
    check("rst_if_rdata", if_rdata, 0); check("rst_dm_rdata", dm_rdata, 0);
    @(negedge clk) rst_n = 1'b1;

    // ---- reset in the middle of a read, then the held request completes
    preload(8'h04, 32'h1234_5678);
    @(negedge clk); if_req = 1; if_addr = 32'h8000_0010;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("mid_oe_active", oe_n, 0);
    rst_n = 1'b0; #1;
    check("mid_ce_n", ce_n, 1); check("mid_oe_n", oe_n, 1); check("mid_be_n", ram_be_n, 4'hF);
    check("mid_if_ready", if_ready, 0); check("mid_if_rdata", if_rdata, 0);
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    while (!if_ready && n < 20) begin @(posedge clk); @(negedge clk); n++; end
    check("mid_relat", n, W+1); check("mid_rdata", if_rdata, 32'h1234_5678);
    if_req = 0;

    // ---- single accesses from the vector table
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      if (v.pre_en) preload(v.addr[9:2], v.pre);
      old_other = v.is_dm ? if_rdata : dm_rdata;
      @(negedge clk);
      if (v.is_dm) begin
        dm_req = 1; dm_we = v.we; dm_be = v.be; dm_addr = v.addr; dm_wdata = v.wdata;
      end else begin
        if_req = 1; if_addr = v.addr;
      end
      #1 check($sformatf("v%0d_stall", i), v.is_dm ? dm_stall : if_stall, 1);
      n = 0; strobe = 0; done = 0; seen_addr = 0; seen_be = 4'hF; hold_bus = 0;
      while (!done && n < 20) begin
        @(posedge clk); @(negedge clk); n++;
        rdy = v.is_dm ? dm_ready : if_ready;
        if (rdy) done = 1;
        else begin
          if (!ce_n) begin seen_addr = ram_addr; seen_be = ram_be_n; end
          if (!oe_n || !we_n) strobe++;
          if (!ce_n && we_n && oe_n) hold_bus = ram_data;
        end
      end
      check($sformatf("v%0d_latency", i), n, v.exp_lat);
      check($sformatf("v%0d_strobe_cycles", i), strobe, W);
      check($sformatf("v%0d_addr", i), seen_addr, v.exp_addr);
      check($sformatf("v%0d_be_n", i), seen_be, v.exp_be_n);
      if (v.we) begin
        check($sformatf("v%0d_whold_bus", i), hold_bus, v.wdata);
        check($sformatf("v%0d_mem", i), mem[v.addr[9:2]], v.exp_word);
      end else begin
        check($sformatf("v%0d_rdata", i), v.is_dm ? dm_rdata : if_rdata, v.exp_word);
      end
      check($sformatf("v%0d_other_hold", i), v.is_dm ? if_rdata : dm_rdata, old_other);
      if_req = 0; dm_req = 0;
      @(negedge clk);
      check($sformatf("v%0d_ready_pulse", i), v.is_dm ? dm_ready : if_ready, 0);
    end

    // ---- simultaneous requests: DM first, IF after DONE + IDLE
    @(negedge clk);
    if_req = 1; if_addr = 32'h8000_0010;
    dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h8000_0200;
    n = 0; dm_n = 0; if_n = 0; stall_bad = 0;
    #1 if (!if_stall) stall_bad++;
    while (if_n == 0 && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
      if (dm_ready) begin dm_n = n; dm_req = 0; end
      if (if_ready) if_n = n;
      else if (!if_stall) stall_bad++;
    end
    check("conf_dm_latency", dm_n, W+1);
    check("conf_if_latency", if_n, 2*W+3);
    check("conf_if_stall", stall_bad, 0);
    check("conf_if_rdata", if_rdata, 32'h1234_5678);
    check("conf_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    if_req = 0;

    // ---- both requests held for four grants
    @(negedge clk);
    if_req = 1; dm_req = 1;
    g = 0; n = 0;
    while (g < 4 && n < 40) begin
      @(posedge clk); @(negedge clk); n++;
      if (dm_ready) begin got_ord[g] = 1; g++; end
      else if (if_ready) begin got_ord[g] = 0; g++; end
    end
    if_req = 0; dm_req = 0;
    check("held_grant_count", g, 4);
    for (int k = 0; k < 4; k++)
      if (k < g) check($sformatf("held_grant%0d_is_dm", k), 32'(got_ord[k]), 32'(exp_ord[k]));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
